// File: rtl/axi_lite_arbiter_pkg.sv
// Shared types and constants for the two-master AXI-lite arbiter.
package ysyx_24110015_axi_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned RESP_W = 2;
    localparam int unsigned SIZE_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        IFU_R,
        LSU_R,
        LSU_W,
        IFU_WERR
    } arb_state_t;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
    localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

    localparam logic [SIZE_W-1:0] SIZE_B = 3'b000;
    localparam logic [SIZE_W-1:0] SIZE_H = 3'b001;
    localparam logic [SIZE_W-1:0] SIZE_W_ = 3'b010;

endpackage

// File: rtl/axi_lite_if.sv
// AXI-lite bundle with transfer size on both address channels.
interface axi_lite_if;
    import ysyx_24110015_axi_pkg::*;

    logic [ADDR_W-1:0] awaddr;
    logic [SIZE_W-1:0] awsize;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [RESP_W-1:0] bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [SIZE_W-1:0] arsize;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [RESP_W-1:0] rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arsize, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arsize, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi_lite_arbiter.sv
// Serialises IFU and LSU AXI-lite traffic onto one downstream bus, one transaction at a time.
module axi_lite_arbiter
    import ysyx_24110015_axi_pkg::*;
#(
    parameter bit                LSU_FIRST      = 1'b1,
    parameter logic [RESP_W-1:0] IFU_WRITE_RESP = RESP_SLVERR
) (
    input logic         clk,
    input logic         rst,
    axi_lite_if.slave   ifu_if,
    axi_lite_if.slave   lsu_if,
    axi_lite_if.master  mem_if
);

    arb_state_t state;
    logic       aw_done_q;
    logic       w_done_q;

    // The IFU write payload is absorbed locally and never reaches the bus.
    logic unused_ifu_wr;
    assign unused_ifu_wr = ^{ifu_if.awaddr, ifu_if.awsize, ifu_if.wdata, ifu_if.wstrb};

    // Grant decision, transaction completion and IFU write-error bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                    if (!LSU_FIRST && ifu_if.arvalid)            state <= IFU_R;
                    else if (lsu_if.awvalid || lsu_if.wvalid)    state <= LSU_W;
                    else if (lsu_if.arvalid)                     state <= LSU_R;
                    else if (ifu_if.arvalid)                     state <= IFU_R;
                    else if (ifu_if.awvalid || ifu_if.wvalid)    state <= IFU_WERR;
                end
                IFU_R, LSU_R: begin
                    if (mem_if.rvalid && mem_if.rready) state <= IDLE;
                end
                LSU_W: begin
                    if (mem_if.bvalid && mem_if.bready) state <= IDLE;
                end
                IFU_WERR: begin
                    if (ifu_if.awvalid && ifu_if.awready) aw_done_q <= 1'b1;
                    if (ifu_if.wvalid && ifu_if.wready)   w_done_q  <= 1'b1;
                    if (ifu_if.bvalid && ifu_if.bready) begin
                        state     <= IDLE;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Channel mux: route the granted master to the bus, everything else reads zero.
    always_comb begin
        mem_if.awaddr  = '0;
        mem_if.awsize  = '0;
        mem_if.awvalid = 1'b0;
        mem_if.wdata   = '0;
        mem_if.wstrb   = '0;
        mem_if.wvalid  = 1'b0;
        mem_if.bready  = 1'b0;
        mem_if.araddr  = '0;
        mem_if.arsize  = '0;
        mem_if.arvalid = 1'b0;
        mem_if.rready  = 1'b0;

        ifu_if.awready = 1'b0;
        ifu_if.wready  = 1'b0;
        ifu_if.bresp   = '0;
        ifu_if.bvalid  = 1'b0;
        ifu_if.arready = 1'b0;
        ifu_if.rdata   = '0;
        ifu_if.rresp   = '0;
        ifu_if.rvalid  = 1'b0;

        lsu_if.awready = 1'b0;
        lsu_if.wready  = 1'b0;
        lsu_if.bresp   = '0;
        lsu_if.bvalid  = 1'b0;
        lsu_if.arready = 1'b0;
        lsu_if.rdata   = '0;
        lsu_if.rresp   = '0;
        lsu_if.rvalid  = 1'b0;

        case (state)
            IFU_R: begin
                mem_if.araddr  = ifu_if.araddr;
                mem_if.arsize  = ifu_if.arsize;
                mem_if.arvalid = ifu_if.arvalid;
                mem_if.rready  = ifu_if.rready;
                ifu_if.arready = mem_if.arready;
                ifu_if.rdata   = mem_if.rdata;
                ifu_if.rresp   = mem_if.rresp;
                ifu_if.rvalid  = mem_if.rvalid;
            end
            LSU_R: begin
                mem_if.araddr  = lsu_if.araddr;
                mem_if.arsize  = lsu_if.arsize;
                mem_if.arvalid = lsu_if.arvalid;
                mem_if.rready  = lsu_if.rready;
                lsu_if.arready = mem_if.arready;
                lsu_if.rdata   = mem_if.rdata;
                lsu_if.rresp   = mem_if.rresp;
                lsu_if.rvalid  = mem_if.rvalid;
            end
            LSU_W: begin
                mem_if.awaddr  = lsu_if.awaddr;
                mem_if.awsize  = lsu_if.awsize;
                mem_if.awvalid = lsu_if.awvalid;
                mem_if.wdata   = lsu_if.wdata;
                mem_if.wstrb   = lsu_if.wstrb;
                mem_if.wvalid  = lsu_if.wvalid;
                mem_if.bready  = lsu_if.bready;
                lsu_if.awready = mem_if.awready;
                lsu_if.wready  = mem_if.wready;
                lsu_if.bresp   = mem_if.bresp;
                lsu_if.bvalid  = mem_if.bvalid;
            end
            IFU_WERR: begin
                // Accept both halves of the write, then answer with an error response.
                ifu_if.awready = !(aw_done_q && w_done_q);
                ifu_if.wready  = !(aw_done_q && w_done_q);
                ifu_if.bvalid  = aw_done_q && w_done_q;
                ifu_if.bresp   = IFU_WRITE_RESP;
            end
            default: ;
        endcase
    end

endmodule
